// File: rtl/mam_burst_split_pkg.sv
// Shared types and constants for the MAM burst splitter.
package mam_burst_split_pkg;

  // Width of the per-sub-request beat count on the req_* port.
  localparam int BEAT_W = 14;

  // Splitter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2
  } state_e;

  // Bytes per data word for a given word width.
  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/mam_burst_split_if.sv
// Bus bundles around the MAM burst splitter.
//
// Handshake rule for every valid/ready pair below: the source raises valid
// and keeps it and its payload stable until the sink has ready high in the
// same cycle; a transfer happens on exactly the rising clock edge where
// valid && ready. Ready may depend combinationally on valid; valid never
// depends on ready.

// Upstream side: one long request plus its write and read data streams.
// master = requester, slave = splitter.
interface mam_up_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 32,
  parameter int WORDS_WIDTH = 16
);
  logic                      up_req_valid;
  logic                      up_req_ready;
  logic                      up_req_rw;
  logic [ADDR_WIDTH-1:0]     up_req_addr;
  logic                      up_req_burst;
  logic [WORDS_WIDTH-1:0]    up_req_words;
  logic                      up_done;
  logic                      up_wr_valid;
  logic [DATA_WIDTH-1:0]     up_wr_data;
  logic [DATA_WIDTH/8-1:0]   up_wr_strb;
  logic                      up_wr_ready;
  logic                      up_rd_valid;
  logic [DATA_WIDTH-1:0]     up_rd_data;
  logic                      up_rd_ready;

  modport master (
    output up_req_valid, up_req_rw, up_req_addr, up_req_burst, up_req_words,
    output up_wr_valid, up_wr_data, up_wr_strb, up_rd_ready,
    input  up_req_ready, up_done, up_wr_ready, up_rd_valid, up_rd_data
  );

  modport slave (
    input  up_req_valid, up_req_rw, up_req_addr, up_req_burst, up_req_words,
    input  up_wr_valid, up_wr_data, up_wr_strb, up_rd_ready,
    output up_req_ready, up_done, up_wr_ready, up_rd_valid, up_rd_data
  );
endinterface

// Downstream side towards the Wishbone master: legal sub-requests plus
// data streams. master = splitter, slave = Wishbone interface.
interface mam_wb_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
);
  logic                                     req_valid;
  logic                                     req_ready;
  logic                                     req_rw;
  logic [ADDR_WIDTH-1:0]                    req_addr;
  logic                                     req_burst;
  logic [mam_burst_split_pkg::BEAT_W-1:0]   req_beats;
  logic                                     write_valid;
  logic [DATA_WIDTH-1:0]                    write_data;
  logic [DATA_WIDTH/8-1:0]                  write_strb;
  logic                                     write_ready;
  logic                                     read_valid;
  logic [DATA_WIDTH-1:0]                    read_data;
  logic                                     read_ready;

  modport master (
    output req_valid, req_rw, req_addr, req_burst, req_beats,
    output write_valid, write_data, write_strb, read_ready,
    input  req_ready, write_ready, read_valid, read_data
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_burst, req_beats,
    input  write_valid, write_data, write_strb, read_ready,
    output req_ready, write_ready, read_valid, read_data
  );
endinterface

// File: rtl/mam_burst_split_chunk.sv
// Size of the next legal sub-request: the smallest of the words still
// outstanding, the per-request beat limit and the words left before the
// next address boundary. Purely combinational.
module mam_burst_split_chunk
  import mam_burst_split_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int WORDS_WIDTH = 16,
  parameter int MAX_BEATS   = 256,
  parameter int BOUNDARY    = 1024,
  parameter int BYTES       = 2
) (
  input  logic [WORDS_WIDTH-1:0] rem_i,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  output logic [BEAT_W-1:0]      beats_o
);

  localparam int ABITS = $clog2(BYTES);
  localparam int CW0   = (ADDR_WIDTH + 1 > WORDS_WIDTH) ? ADDR_WIDTH + 1 : WORDS_WIDTH;
  localparam int CW    = (CW0 > BEAT_W) ? CW0 : BEAT_W;

  // One extra bit so a boundary-aligned address yields the full BOUNDARY.
  localparam logic [ADDR_WIDTH:0]   BND      = (ADDR_WIDTH + 1)'(BOUNDARY);
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'(BOUNDARY - 1);

  logic [ADDR_WIDTH:0] room_bytes;
  logic [CW-1:0]       room_w;
  logic [CW-1:0]       rem_w;
  logic [CW-1:0]       lim_w;

  // Three-way minimum evaluated at a common width.
  always_comb begin
    room_bytes = BND - {1'b0, addr_i & OFS_MASK};
    room_w     = CW'(room_bytes >> ABITS);
    rem_w      = CW'(rem_i);
    lim_w      = CW'(MAX_BEATS);
    if (rem_w < lim_w) lim_w = rem_w;
    if (room_w < lim_w) lim_w = room_w;
    beats_o    = BEAT_W'(lim_w);
  end

endmodule

// File: rtl/mam_burst_split.sv
// Splits one long MAM memory request into boundary- and length-legal
// sub-requests, issues them one at a time and steers the data streams so
// each beat belongs to the sub-request currently in flight.
module mam_burst_split
  import mam_burst_split_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 32,
  parameter int WORDS_WIDTH = 16,
  parameter int MAX_BEATS   = 256,
  parameter int BOUNDARY    = 1024
) (
  input  logic   CLK_I,
  input  logic   RST_NI,
  mam_up_if.slave up,
  mam_wb_if.master wb,
  output state_e state_o
);

  localparam int BYTES = bytes_of(DATA_WIDTH);
  localparam int ABITS = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

  state_e                 state_q;
  logic                   rw_q;
  logic                   burst_q;
  logic [ADDR_WIDTH-1:0]  addr_q;       // start address of the current chunk
  logic [WORDS_WIDTH-1:0] remaining_q;  // words left, including current chunk
  logic [BEAT_W-1:0]      beats_q;      // size of the current chunk
  logic [BEAT_W-1:0]      chunk_cnt_q;  // beats still due in the current chunk
  logic                   req_valid_q;
  logic                   done_q;

  logic [WORDS_WIDTH-1:0] chunk_rem;
  logic [ADDR_WIDTH-1:0]  chunk_addr;
  logic [BEAT_W-1:0]      chunk_beats;
  logic                   xfer_wr;
  logic                   xfer_rd;
  logic                   beat;

  // Source of the next chunk: the incoming request while idle, otherwise
  // the position just past the chunk now in flight.
  always_comb begin
    if (state_q == IDLE) begin
      chunk_rem  = up.up_req_burst ? up.up_req_words : WORDS_WIDTH'(1);
      chunk_addr = up.up_req_addr & ALIGN_MASK;
    end else begin
      chunk_rem  = remaining_q - WORDS_WIDTH'(beats_q);
      chunk_addr = addr_q + (ADDR_WIDTH'(beats_q) << ABITS);
    end
  end

  mam_burst_split_chunk #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WORDS_WIDTH (WORDS_WIDTH),
    .MAX_BEATS   (MAX_BEATS),
    .BOUNDARY    (BOUNDARY),
    .BYTES       (BYTES)
  ) u_chunk (
    .rem_i   (chunk_rem),
    .addr_i  (chunk_addr),
    .beats_o (chunk_beats)
  );

  // Only the direction of the latched request is opened, and only while a
  // chunk is in flight, so no beat can slip into a neighbouring chunk.
  assign xfer_wr = (state_q == XFER) && rw_q;
  assign xfer_rd = (state_q == XFER) && !rw_q;

  assign wb.write_valid = xfer_wr && up.up_wr_valid;
  assign wb.write_data  = up.up_wr_data;
  assign wb.write_strb  = up.up_wr_strb;
  assign up.up_wr_ready = xfer_wr && wb.write_ready;

  assign up.up_rd_valid = xfer_rd && wb.read_valid;
  assign up.up_rd_data  = wb.read_data;
  assign wb.read_ready  = xfer_rd && up.up_rd_ready;

  assign beat = (wb.write_valid && wb.write_ready) || (wb.read_valid && wb.read_ready);

  assign up.up_req_ready = (state_q == IDLE);
  assign up.up_done      = done_q;
  assign wb.req_valid    = req_valid_q;
  assign wb.req_rw       = rw_q;
  assign wb.req_addr     = addr_q;
  assign wb.req_burst    = burst_q;
  assign wb.req_beats    = beats_q;
  assign state_o         = state_q;

  // Control FSM with counters and registered request/done outputs.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q     <= IDLE;
      rw_q        <= 1'b0;
      burst_q     <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      chunk_cnt_q <= '0;
      req_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (up.up_req_valid) begin
            rw_q        <= up.up_req_rw;
            burst_q     <= up.up_req_burst;
            addr_q      <= chunk_addr;
            remaining_q <= chunk_rem;
            if (chunk_rem == '0) begin
              done_q <= 1'b1;
            end else begin
              beats_q     <= chunk_beats;
              req_valid_q <= 1'b1;
              state_q     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (wb.req_ready) begin
            req_valid_q <= 1'b0;
            chunk_cnt_q <= beats_q;
            state_q     <= XFER;
          end
        end
        XFER: begin
          if (beat) begin
            chunk_cnt_q <= chunk_cnt_q - BEAT_W'(1);
            if (chunk_cnt_q == BEAT_W'(1)) begin
              remaining_q <= chunk_rem;
              addr_q      <= chunk_addr;
              if (chunk_rem == '0) begin
                done_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                beats_q     <= chunk_beats;
                req_valid_q <= 1'b1;
                state_q     <= ISSUE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
